// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: opcodes, NOP encoding, fetch FSM states and fetch-entry layout.
// Pure declarations; no timing or flow-control behaviour of its own.
package rv_core_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_ent_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid channel plus the valid/ready link to decode.
// Master is the fetch unit; slave is the memory/decode side.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc,
    output id_ready
  );
endinterface

// File: rtl/if_out_reg.sv
// One-entry fetch output register (valid/instr/pc); load lands next cycle.
// Holds while valid & ~accept; clear beats load, load beats accept.
module if_out_reg
  import rv_core_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] load_instr_i,
  input  logic [31:0] load_pc_i,
  input  logic        accept_i,
  input  logic        clear_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic       valid_q, valid_d;
  fetch_ent_t ent_q, ent_d;

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    if (load_i) begin
      ent_d.instr = load_instr_i;
      ent_d.pc    = load_pc_i;
    end
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
    end else if (accept_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= 1'b0;
      ent_q.instr <= INSTR_NOP;
      ent_q.pc    <= 32'h0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = ent_q.instr;
  assign pc_o    = ent_q.pc;

endmodule

// File: rtl/pc_fetch_unit.sv
// RV32I fetch stage: owns the PC, one outstanding imem request, redirect/kill of wrong-path fetches.
// Zero-wait memory gives 2-cycle req-to-valid, 1 instr / 2 cycles; no request while output is held by decode.
module pc_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ex_valid_i,
  input  logic                   branch_condition_i,
  input  logic [31:0]            branch_target_i,
  output logic                   flush_o,
  pc_fetch_unit_if.master        fetch
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         kill_q, kill_d;

  logic redir;
  logic grant;
  logic rsp;
  logic load;
  logic out_valid;

  assign redir   = ex_valid_i & branch_condition_i;
  assign flush_o = redir;

  // Issuing only when the output slot is free (or draining this cycle) guarantees room for the response.
  assign fetch.imem_req  = (state_q == FS_REQ) & (~out_valid | fetch.id_ready) & ~redir;
  assign fetch.imem_addr = pc_q;
  assign grant           = fetch.imem_req & fetch.imem_gnt;
  assign rsp             = (state_q == FS_WAIT) & fetch.imem_rvalid;
  assign load            = rsp & ~kill_q & ~redir;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q;
    case (state_q)
      FS_BOOT: state_d = FS_REQ;
      FS_REQ: begin
        if (grant) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (fetch.imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = FS_REQ;
        end
      end
      default: state_d = FS_BOOT;
    endcase

    // A redirect with the old-path response still in flight must discard exactly that response.
    if (redir) begin
      pc_d = align_word(branch_target_i);
      if ((state_q == FS_WAIT) && !fetch.imem_rvalid) begin
        kill_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FS_BOOT;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
    end
  end

  if_out_reg u_out_reg (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (load),
    .load_instr_i (fetch.imem_rdata),
    .load_pc_i    (req_pc_q),
    .accept_i     (fetch.id_ready),
    .clear_i      (redir),
    .valid_o      (out_valid),
    .instr_o      (fetch.if_instr),
    .pc_o         (fetch.if_pc)
  );

  assign fetch.if_valid = out_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: memory model, random decode/redirect stimulus, directed corner cases.
module tb_pc_fetch_unit;
  import rv_core_pkg::*;

  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        br_cond = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        flush;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .ex_valid_i         (ex_valid),
    .branch_condition_i (br_cond),
    .branch_target_i    (br_target),
    .flush_o            (flush),
    .fetch              (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_pc;
  logic [31:0] last_pc = 32'h0;
  int acc_cnt = 0;

  int gnt_pct = 100;
  int dly_min = 0;
  int dly_max = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: one transaction at a time, no grant while busy, data = addr ^ XOR_KEY; survives core reset.
  logic        mem_pending = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.imem_rvalid) mem_pending = 1'b0;
      if (rst_n && bus.imem_req && bus.imem_gnt) begin
        mem_pending = 1'b1;
        mem_addr    = bus.imem_addr;
        mem_cnt     = $urandom_range(dly_max, dly_min);
      end
      @(posedge clk);
      #1;
      if (mem_pending && mem_cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_addr ^ XOR_KEY;
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (mem_pending) mem_cnt--;
      end
      bus.imem_gnt = !mem_pending && ($urandom_range(99, 0) < gnt_pct);
    end
  end

  // Monitor: protocol checks every cycle; every decode acceptance pops the next expected PC.
  always @(negedge clk) begin
    if (rst_n) begin
      check("flush", 32'(flush), 32'(ex_valid & br_cond));
      if (bus.imem_req) begin
        check("req_while_full", 32'(bus.if_valid & ~bus.id_ready), 32'd0);
        check("req_during_flush", 32'(flush), 32'd0);
        check("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
      end
      if (bus.if_valid && bus.id_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %h with no expectation", bus.if_pc);
        end else begin
          sb_pc = exp_q.pop_front();
          check("out_pc", bus.if_pc, sb_pc);
          check("out_instr", bus.if_instr, sb_pc ^ XOR_KEY);
          exp_q.push_back(sb_pc + 32'd4);
          acc_cnt++;
          last_pc = bus.if_pc;
        end
      end
    end
  end

  task automatic redirect(input logic [31:0] tgt);
    ex_valid  = 1'b1;
    br_cond   = 1'b1;
    br_target = tgt;
    exp_q.delete();
    exp_q.push_back(tgt & ~32'h3);
  endtask

  task automatic wait_grant(output logic [31:0] addr);
    bit ok;
    ok = 1'b0;
    addr = 32'h0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_gnt) begin
        ok = 1'b1;
        addr = bus.imem_addr;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL grant_timeout: got no grant within 100 cycles, required one");
    end
  endtask

  task automatic wait_accepts(input int n);
    int base;
    base = acc_cnt;
    for (int k = 0; k < 300 && acc_cnt < base + n; k++) @(negedge clk);
    check("accept_timeout", 32'(acc_cnt - base >= n), 32'd1);
  endtask

  logic [31:0] ga;
  logic [31:0] tgt;

  initial begin
    bus.id_ready = 1'b1;
    exp_q.push_back(RST_PC);
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", bus.imem_addr, RST_PC);
    check("rst_valid", 32'(bus.if_valid), 32'd0);
    check("rst_instr", bus.if_instr, INSTR_NOP);
    check("rst_pc", bus.if_pc, 32'h0);
    rst_n = 1'b1;
    #1 check("boot_no_req", 32'(bus.imem_req), 32'd0);

    // Zero-wait memory: 2-cycle latency, one instruction every other cycle.
    @(negedge clk);
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, RST_PC);
    @(negedge clk);
    check("lat_c1_valid", 32'(bus.if_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_valid", 32'(bus.if_valid), 32'd1);
    check("second_addr", bus.imem_addr, RST_PC + 32'd4);
    @(negedge clk);
    check("gap_valid", 32'(bus.if_valid), 32'd0);

    // Decode stall.
    @(posedge clk); #1 bus.id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_no_req", 32'(bus.imem_req), 32'd0);
      check("stall_valid", 32'(bus.if_valid), 32'd1);
      check("stall_instr", bus.if_instr, (RST_PC + 32'd4) ^ XOR_KEY);
    end
    @(posedge clk); #1 bus.id_ready = 1'b1;
    @(negedge clk);
    check("resume_req", 32'(bus.imem_req), 32'd1);
    check("resume_addr", bus.imem_addr, RST_PC + 32'd8);

    // Random traffic with redirects.
    gnt_pct = 70;
    dly_min = 0;
    dly_max = 3;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.id_ready = ($urandom_range(99, 0) < 80);
      ex_valid     = 1'b0;
      br_cond      = 1'b0;
      br_target    = $urandom;
      if ($urandom_range(99, 0) < 7) begin
        if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        else tgt = $urandom;
        redirect(tgt);
      end else begin
        ex_valid = $urandom_range(1, 0);
        br_cond  = ~ex_valid & $urandom_range(1, 0);
      end
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; br_cond = 1'b0; bus.id_ready = 1'b1;
    check("random_progress", 32'(acc_cnt > 200), 32'd1);

    // Wraparound past 0xFFFF_FFFC.
    gnt_pct = 100; dly_min = 0; dly_max = 0;
    @(posedge clk); #1 redirect(32'hFFFF_FFFA);
    @(posedge clk); #1 begin ex_valid = 1'b0; br_cond = 1'b0; end
    wait_accepts(3);
    check("wrap_pc", last_pc, 32'h0);

    // Redirect in WAIT, response 3 cycles late.
    dly_min = 3; dly_max = 3;
    wait_grant(ga);
    @(posedge clk); #1 redirect(32'h0000_2003);
    @(negedge clk);
    check("wait_flush", 32'(flush), 32'd1);
    @(posedge clk); #1 begin ex_valid = 1'b0; br_cond = 1'b0; end
    wait_grant(ga);
    check("wait_redir_addr", ga, 32'h0000_2000);
    wait_accepts(1);
    check("wait_redir_pc", last_pc, 32'h0000_2000);

    // Redirect coinciding with rvalid.
    dly_min = 1; dly_max = 1;
    wait_grant(ga);
    @(posedge clk); #1;
    @(posedge clk); #1 redirect(32'h0000_3000);
    @(negedge clk);
    check("same_rvalid", 32'(bus.imem_rvalid), 32'd1);
    @(posedge clk); #1 begin ex_valid = 1'b0; br_cond = 1'b0; end
    @(negedge clk);
    check("same_valid", 32'(bus.if_valid), 32'd0);
    check("same_req", 32'(bus.imem_req), 32'd1);
    check("same_addr", bus.imem_addr, 32'h0000_3000);
    wait_accepts(1);

    // Reset while waiting; the late response must be ignored.
    dly_min = 3; dly_max = 3;
    wait_grant(ga);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    #1;
    check("arst_req", 32'(bus.imem_req), 32'd0);
    check("arst_valid", 32'(bus.if_valid), 32'd0);
    check("arst_addr", bus.imem_addr, RST_PC);
    @(negedge clk) rst_n = 1'b1;
    dly_min = 0; dly_max = 0;
    wait_grant(ga);
    check("post_rst_addr", ga, RST_PC);
    wait_accepts(1);
    check("post_rst_pc", last_pc, RST_PC);

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
